// File: rtl/uart_alu_sequencer.sv
// Sequencer between UART rx/tx and the ALU: gathers A, opcode, B, then sends one result byte.
// An inter-byte timeout in baud ticks aborts a stalled operation back to WAIT_A.
//
// state   | meaning
// WAIT_A  | idle, waiting for operand A byte
// WAIT_OP | waiting for opcode byte (timeout armed)
// WAIT_B  | waiting for operand B byte (timeout armed)
// LATCH   | ALU settles on registered inputs, result captured
// SEND    | tx start pulse
// WAIT_TX | waiting for transmitter to finish
module uart_alu_sequencer #(
  parameter int NB_BITS       = 8,
  parameter int NB_OP         = 6,
  parameter int NB_TIMEOUT    = 16,
  parameter int TIMEOUT_TICKS = 40000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_tick,
  input  logic [NB_BITS-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  input  logic [NB_BITS-1:0] i_alu_result,
  output logic [NB_BITS-1:0] o_alu_a,
  output logic [NB_BITS-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_BITS-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_timeout_err
);

  typedef enum logic [2:0] {
    ST_WAIT_A,
    ST_WAIT_OP,
    ST_WAIT_B,
    ST_LATCH,
    ST_SEND,
    ST_WAIT_TX
  } state_t;

  localparam logic [NB_TIMEOUT-1:0] TERM_CNT = NB_TIMEOUT'(TIMEOUT_TICKS - 1);

  state_t                state, state_next;
  logic [NB_TIMEOUT-1:0] cnt, cnt_next;
  logic                  ld_a, ld_op, ld_b, ld_res, timeout_hit;

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    ld_a        = 1'b0;
    ld_op       = 1'b0;
    ld_b        = 1'b0;
    ld_res      = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_WAIT_A: begin
        cnt_next = '0;
        if (i_rx_done) begin
          ld_a       = 1'b1;
          state_next = ST_WAIT_OP;
        end
      end
      ST_WAIT_OP, ST_WAIT_B: begin
        // An accepted byte wins over a coincident terminal tick.
        if (i_rx_done) begin
          cnt_next   = '0;
          ld_op      = (state == ST_WAIT_OP);
          ld_b       = (state == ST_WAIT_B);
          state_next = (state == ST_WAIT_OP) ? ST_WAIT_B : ST_LATCH;
        end else if (i_tick) begin
          if (cnt == TERM_CNT) begin
            timeout_hit = 1'b1;
            cnt_next    = '0;
            state_next  = ST_WAIT_A;
          end else begin
            cnt_next = cnt + NB_TIMEOUT'(1);
          end
        end
      end
      ST_LATCH: begin
        ld_res     = 1'b1;
        cnt_next   = '0;
        state_next = ST_SEND;
      end
      ST_SEND: begin
        state_next = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (i_tx_done) state_next = ST_WAIT_A;
      end
      default: begin
        cnt_next   = '0;
        state_next = ST_WAIT_A;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= ST_WAIT_A;
      cnt           <= '0;
      o_alu_a       <= '0;
      o_alu_b       <= '0;
      o_alu_op      <= '0;
      o_tx_data     <= '0;
      o_tx_start    <= 1'b0;
      o_timeout_err <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      o_tx_start    <= (state_next == ST_SEND);
      o_timeout_err <= timeout_hit;
      if (ld_a)   o_alu_a   <= i_rx_data;
      if (ld_op)  o_alu_op  <= i_rx_data[NB_OP-1:0];
      if (ld_b)   o_alu_b   <= i_rx_data;
      if (ld_res) o_tx_data <= i_alu_result;
    end
  end

  assign o_busy = (state != ST_WAIT_A);

endmodule
